comm_cmd_responder: RTL and testbench
=====================================

// Module: comm_cmd_responder
// PURPOSE
//  Receive-side command responder for the UART link. Sits between uart_rx (byte + 1-cycle valid) and uart_tx (DV/active/done).
//  Decodes single-byte ASCII commands from the host, updates a GP output register or samples GP inputs, and answers each
//  command with one response byte through the same transmit handshake the periodic-beacon logic uses.
// PARAMETERS
//  TIMEOUT_CLKS  500000  max CLK_50 cycles between 'W' and its data byte (10 ms @ 50 MHz); 0 not allowed
// PORTS
//  CLK_50    in   1  system clock, 50 MHz; single clock domain
//  RST       in   1  asynchronous, active-high reset
//  rx_dv     in   1  1-cycle strobe from uart_rx: rx_byte valid
//  rx_byte   in   8  received byte
//  tx_active in   1  uart_tx busy
//  tx_done   in   1  uart_tx 1-cycle frame-complete strobe
//  gp_in     in   8  general-purpose inputs (already synchronous to CLK_50)
//  tx_dv     out  1  1-cycle start strobe to uart_tx
//  tx_byte   out  8  response byte; held stable from tx_dv until tx_done
//  gp_out    out  8  general-purpose output register
//  overrun   out  1  sticky: a received byte was dropped
//  busy      out  1  high whenever state != IDLE or pending byte held
// BEHAVIOUR
//  Reset (async, immediate): tx_dv=0, tx_byte=8'h00, gp_out=8'h00, overrun=0, busy=0, pending empty, state IDLE, timer 0.
//  Pending buffer (1 entry): rx_dv loads rx_byte if empty, or if the parser consumes it in the same cycle (no overrun).
//   rx_dv while full and not consumed -> byte dropped, overrun<=1. Only 'C' or RST clears overrun.
//  Commands (consumed from pending in IDLE):
//   'W' (8'h57) -> WAIT_DATA; next pending byte (any value) -> gp_out<=byte, response 'K' (8'h4B)
//   'R' (8'h52) -> response = gp_in sampled in the consume cycle
//   'C' (8'h43) -> overrun<=0, response 'K'
//   other       -> response '?' (8'h3F); gp_out unchanged
//  WAIT_DATA: timer counts each cycle with pending empty; timer==TIMEOUT_CLKS-1 -> response 'T' (8'h54), gp_out unchanged.
//   Timer cleared on entry to WAIT_DATA. Byte consumed on the same cycle as expiry wins (data accepted, 'K').
//  States: IDLE -> (WAIT_DATA) -> WAIT_READY -> WAIT_DONE -> IDLE.
//   Consume cycle loads tx_byte with the response, enters WAIT_READY.
//   WAIT_READY: tx_active==0 -> tx_dv<=1 for exactly one cycle, enter WAIT_DONE; else stay.
//   WAIT_DONE: tx_done==1 -> IDLE. tx_done in any other state ignored.
//  Latency: tx idle, pending empty, rx_dv in cycle N -> tx_dv high in cycle N+3 (N+1 pending, N+2 WAIT_READY).
//  Pending not consumed in WAIT_READY/WAIT_DONE; one byte may queue during a response, a second sets overrun.
//  Exactly one response per command; responses never overlap (new tx_dv only after tx_done).
//  Reset mid-frame: state returns IDLE immediately; a uart_tx frame already started completes and its tx_done is ignored.
//  Timer width $clog2(TIMEOUT_CLKS)+1; saturating comparison, no wrap.
// STRUCTURE
//  comm_pkg: state encodings (3-bit), command/response ASCII constants (CMD_W/R/C, RSP_K/Q/T).
//  Sub-module comm_byte_buf: 1-entry pending buffer (load, consume, full, overrun pulse); FSM + timer stay in top.
//  Instantiated in comm alongside uart_rx/uart_tx; the beacon FSM and this block arbitrate tx by priority mux (not here).
// TESTING
//  1 Write: rx 'W' then 8'hA5 (tx_active=0) -> gp_out==8'hA5, tx_byte=='K', tx_dv single pulse at N+3 after data rx_dv.
//  2 Read: gp_in=8'h3C, rx 'R' -> tx_byte==8'h3C, one tx_dv; gp_out unchanged.
//  3 Unknown 'Z' -> tx_byte=='?'; tx_active held high 100 cycles -> tx_dv delayed until tx_active falls, stays one pulse.
//  4 Timeout (TIMEOUT_CLKS=20): rx 'W', no data -> tx_byte=='T' 20 cycles later; data at cycle 19 -> accepted, 'K'.
//  5 Overrun: rx 'R','R','R' back-to-back during WAIT_DONE -> overrun==1, two responses total; then 'C' -> overrun==0, 'K'.
//  6 RST pulse mid WAIT_DONE -> all outputs at reset values same cycle; late tx_done ignored; next 'R' handled normally.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared encodings for the UART command responder: FSM states and the
// single-byte ASCII command / response alphabet spoken with the host.
package comm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_DATA  = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_WAIT_DONE  = 3'd3
    } state_e;

    // Commands received from the host
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_C = 8'h43;

    // Response bytes sent back to the host
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_Q = 8'h3F;
    localparam logic [7:0] RSP_T = 8'h54;

endpackage : comm_pkg

// File: rtl/comm_byte_buf.sv
// One-entry holding buffer between uart_rx and the command parser.
// A new byte may replace the held one only when the parser takes the
// held byte in the same cycle; otherwise the new byte is lost and a
// one-cycle drop pulse is raised so the owner can latch an overrun flag.
module comm_byte_buf (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       consume_i,
    output logic       full_o,
    output logic [7:0] data_o,
    output logic       drop_o
);

    logic       full_q;
    logic [7:0] data_q;
    logic       accept;

    assign accept = load_i && (!full_q || consume_i);
    assign drop_o = load_i && full_q && !consume_i;
    assign full_o = full_q;
    assign data_o = data_q;

    // Occupancy and held byte: a load refills, a bare consume empties.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= 8'h00;
        end else if (accept) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end else if (consume_i) begin
            full_q <= 1'b0;
        end
    end

endmodule : comm_byte_buf

// File: rtl/comm_cmd_responder.sv
// Receive-side command responder. Takes bytes from uart_rx, decodes the
// single-letter host commands, drives the GP output register or samples
// the GP inputs, and answers every command with exactly one byte through
// the uart_tx start/active/done handshake.
module comm_cmd_responder
    import comm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 500000
) (
    input  logic       CLK_50,
    input  logic       RST,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    input  logic       tx_active,
    input  logic       tx_done,
    input  logic [7:0] gp_in,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    output logic [7:0] gp_out,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);

    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic          tx_dv_q;
    logic [7:0]    tx_byte_q;
    logic [7:0]    gp_out_q;
    logic          overrun_q;

    logic          pend_full;
    logic [7:0]    pend_data;
    logic          pend_drop;
    logic          consume_d;

    // The parser only looks at the pending byte while it can act on it;
    // during a response the byte stays queued.
    assign consume_d = pend_full && ((state_q == ST_IDLE) || (state_q == ST_WAIT_DATA));

    comm_byte_buf u_buf (
        .clk_i     (CLK_50),
        .rst_i     (RST),
        .load_i    (rx_dv),
        .data_i    (rx_byte),
        .consume_i (consume_d),
        .full_o    (pend_full),
        .data_o    (pend_data),
        .drop_o    (pend_drop)
    );

    assign tx_dv   = tx_dv_q;
    assign tx_byte = tx_byte_q;
    assign gp_out  = gp_out_q;
    assign overrun = overrun_q;
    assign busy    = (state_q != ST_IDLE) || pend_full;

    // Command FSM with data timeout; all outputs are registered here.
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            gp_out_q  <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            tx_dv_q <= 1'b0;
            if (pend_drop) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pend_full) begin
                        state_q <= ST_WAIT_READY;
                        case (pend_data)
                            CMD_W: begin
                                state_q <= ST_WAIT_DATA;
                                timer_q <= '0;
                            end
                            CMD_R: tx_byte_q <= gp_in;
                            CMD_C: begin
                                overrun_q <= 1'b0;
                                tx_byte_q <= RSP_K;
                            end
                            default: tx_byte_q <= RSP_Q;
                        endcase
                    end
                end
                ST_WAIT_DATA: begin
                    if (pend_full) begin
                        gp_out_q  <= pend_data;
                        tx_byte_q <= RSP_K;
                        state_q   <= ST_WAIT_READY;
                    end else if (timer_q >= TIMER_LAST) begin
                        tx_byte_q <= RSP_T;
                        state_q   <= ST_WAIT_READY;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_WAIT_READY: begin
                    if (!tx_active) begin
                        tx_dv_q <= 1'b1;
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule : comm_cmd_responder

// File: tb/tb_comm_cmd_responder.sv
// Scoreboard bench for comm_cmd_responder. Stimulus pushes the expected
// response byte (and, where it matters, the expected start latency) into
// a queue; an independent monitor pops an entry on every tx_dv pulse.
module tb_comm_cmd_responder;

    logic       CLK_50 = 1'b0;
    logic       RST = 1'b1;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] gp_in = 8'h00;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic [7:0] gp_out;
    logic       overrun;
    logic       busy;

    typedef struct {
        logic [7:0] data;
        int         latency;
        int         rxCycle;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   compared = 0;
    int   mismatched = 0;
    int   txPulses = 0;
    int   cycleCnt = 0;
    int   lastRx = 0;
    int   wCycle = 0;
    int   startPulses = 0;
    logic prevTxDv = 1'b0;

    comm_cmd_responder #(.TIMEOUT_CLKS(20)) dut (
        .CLK_50    (CLK_50),
        .RST       (RST),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .gp_in     (gp_in),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .gp_out    (gp_out),
        .overrun   (overrun),
        .busy      (busy)
    );

    // 50 MHz-style free-running clock
    always #5 CLK_50 = ~CLK_50;

    // Cycle index used to measure rx-to-tx latency
    always @(posedge CLK_50) cycleCnt <= cycleCnt + 1;

    // Monitor: every tx_dv pulse must match the head of the scoreboard
    always @(negedge CLK_50) begin
        if (tx_dv === 1'b1) begin
            txPulses++;
            compared++;
            if (prevTxDv === 1'b1) begin
                mismatched++;
                $display("[TB] FAIL txPulseWidth: tx_dv high on consecutive cycles, got 2+ expected 1");
            end
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpectedTx: got byte %h expected no response", tx_byte);
            end else begin
                monExp = expQ.pop_front();
                if (tx_byte !== monExp.data) begin
                    mismatched++;
                    $display("[TB] FAIL txByte: got %h expected %h", tx_byte, monExp.data);
                end
                if (monExp.latency != 0) begin
                    compared++;
                    if (cycleCnt - monExp.rxCycle != monExp.latency) begin
                        mismatched++;
                        $display("[TB] FAIL txLatency: got %0d expected %0d", cycleCnt - monExp.rxCycle, monExp.latency);
                    end
                end
            end
        end
        prevTxDv = tx_dv;
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge CLK_50);
        #1;
        rx_dv   = 1'b1;
        rx_byte = b;
        lastRx  = cycleCnt;
    endtask

    task automatic idleRx();
        @(posedge CLK_50);
        #1;
        rx_dv = 1'b0;
    endtask

    task automatic pushExp(input logic [7:0] d, input int lat, input int rxc);
        exp_t e;
        e.data    = d;
        e.latency = lat;
        e.rxCycle = rxc;
        expQ.push_back(e);
    endtask

    task automatic waitTxDv();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK_50);
            if (tx_dv === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("[TB] FAIL txDvWait: got no tx_dv expected one within 300 cycles");
        end
    endtask

    task automatic finishTx();
        @(posedge CLK_50);
        #1;
        tx_active = 1'b1;
        repeat (3) @(posedge CLK_50);
        #1;
        tx_done = 1'b1;
        @(posedge CLK_50);
        #1;
        tx_done   = 1'b0;
        tx_active = 1'b0;
    endtask

    task automatic serviceTx();
        waitTxDv();
        finishTx();
    endtask

    // Directed sequence
    initial begin
        repeat (3) @(posedge CLK_50);
        @(negedge CLK_50);
        checkOutput("rstTxDv", {7'b0, tx_dv}, 8'h00);
        checkOutput("rstTxByte", tx_byte, 8'h00);
        checkOutput("rstGpOut", gp_out, 8'h00);
        checkOutput("rstOverrun", {7'b0, overrun}, 8'h00);
        checkOutput("rstBusy", {7'b0, busy}, 8'h00);
        @(posedge CLK_50);
        #1;
        RST = 1'b0;

        // Write command followed by its data byte
        applyStimulus(8'h57);
        idleRx();
        applyStimulus(8'hA5);
        pushExp(8'h4B, 3, lastRx);
        idleRx();
        serviceTx();
        @(negedge CLK_50);
        checkOutput("writeGpOut", gp_out, 8'hA5);
        checkOutput("writeIdleBusy", {7'b0, busy}, 8'h00);

        // Read command returns gp_in
        gp_in = 8'h3C;
        applyStimulus(8'h52);
        pushExp(8'h3C, 3, lastRx);
        idleRx();
        serviceTx();
        checkOutput("readGpOutKept", gp_out, 8'hA5);

        // Unknown command while the transmitter stays busy
        tx_active   = 1'b1;
        startPulses = txPulses;
        applyStimulus(8'h5A);
        pushExp(8'h3F, 0, 0);
        idleRx();
        repeat (100) @(posedge CLK_50);
        @(negedge CLK_50);
        checkOutput("heldNoTx", 8'(txPulses - startPulses), 8'h00);
        checkOutput("heldBusy", {7'b0, busy}, 8'h01);
        @(posedge CLK_50);
        #1;
        tx_active = 1'b0;
        serviceTx();
        checkOutput("heldOnePulse", 8'(txPulses - startPulses), 8'h01);

        // Write with no data byte times out
        applyStimulus(8'h57);
        wCycle = lastRx;
        pushExp(8'h54, 23, wCycle);
        idleRx();
        serviceTx();
        checkOutput("timeoutGpOut", gp_out, 8'hA5);

        // Data arriving in the last timer cycle is still accepted
        applyStimulus(8'h57);
        idleRx();
        repeat (18) @(posedge CLK_50);
        applyStimulus(8'h66);
        pushExp(8'h4B, 3, lastRx);
        idleRx();
        serviceTx();
        checkOutput("lateDataGpOut", gp_out, 8'h66);

        // Overrun: three reads back-to-back while a response is in flight
        gp_in       = 8'h81;
        startPulses = txPulses;
        applyStimulus(8'h52);
        pushExp(8'h81, 3, lastRx);
        idleRx();
        waitTxDv();
        applyStimulus(8'h52);
        applyStimulus(8'h52);
        applyStimulus(8'h52);
        pushExp(8'h81, 0, 0);
        idleRx();
        @(negedge CLK_50);
        checkOutput("overrunSet", {7'b0, overrun}, 8'h01);
        checkOutput("overrunBusy", {7'b0, busy}, 8'h01);
        finishTx();
        serviceTx();
        repeat (10) @(negedge CLK_50);
        checkOutput("overrunTwoResp", 8'(txPulses - startPulses), 8'h02);
        checkOutput("overrunSticky", {7'b0, overrun}, 8'h01);
        applyStimulus(8'h43);
        pushExp(8'h4B, 3, lastRx);
        idleRx();
        serviceTx();
        @(negedge CLK_50);
        checkOutput("clearOverrun", {7'b0, overrun}, 8'h00);

        // Reset in the middle of a response
        applyStimulus(8'h52);
        pushExp(8'h81, 3, lastRx);
        idleRx();
        waitTxDv();
        applyStimulus(8'h52);
        applyStimulus(8'h52);
        @(posedge CLK_50);
        #1;
        rx_dv     = 1'b0;
        tx_active = 1'b1;
        #2;
        RST = 1'b1;
        #1;
        checkOutput("midRstTxDv", {7'b0, tx_dv}, 8'h00);
        checkOutput("midRstTxByte", tx_byte, 8'h00);
        checkOutput("midRstGpOut", gp_out, 8'h00);
        checkOutput("midRstOverrun", {7'b0, overrun}, 8'h00);
        checkOutput("midRstBusy", {7'b0, busy}, 8'h00);
        @(posedge CLK_50);
        #1;
        RST         = 1'b0;
        startPulses = txPulses;
        repeat (3) @(posedge CLK_50);
        #1;
        tx_done = 1'b1;
        @(posedge CLK_50);
        #1;
        tx_done   = 1'b0;
        tx_active = 1'b0;
        repeat (5) @(negedge CLK_50);
        checkOutput("lateDoneNoTx", 8'(txPulses - startPulses), 8'h00);
        checkOutput("lateDoneBusy", {7'b0, busy}, 8'h00);
        gp_in = 8'h9E;
        applyStimulus(8'h52);
        pushExp(8'h9E, 3, lastRx);
        idleRx();
        serviceTx();

        repeat (5) @(negedge CLK_50);
        checkOutput("scoreboardDrained", 8'(expQ.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000 time units");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_comm_cmd_responder
